// File: rtl/modulation_matrix_pipe.sv
// modulation_matrix_pipe: pipelined FM src->dst modulation matrix.
// Build option MODMAT_SAT_EN: saturating limiter plus sticky sat_flag.
module modulation_matrix_pipe #(
    parameter int VOICES  = 8,
    parameter int V_OSC   = 4,
    parameter int V_WIDTH = 3,
    parameter int O_WIDTH = 2,
    parameter int SW      = 17,
    parameter int CW      = 8,
    parameter int OW      = 11,
    parameter int SHIFT   = 24,
    parameter int CA_W    = 5
) (
    input  logic                      sCLK_XVXENVS,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [V_WIDTH-1:0]        in_voice,
    input  logic [O_WIDTH-1:0]        in_osc,
    input  logic signed [SW-1:0]      in_sample,
    input  logic                      cfg_we,
    input  logic [CA_W-1:0]           cfg_addr,
    input  logic signed [CW-1:0]      cfg_data,
    input  logic                      rd_en,
    input  logic [V_WIDTH-1:0]        rd_voice,
    input  logic [O_WIDTH-1:0]        rd_osc,
    output logic signed [OW-1:0]      mod_out,
    output logic                      mod_valid,
    output logic                      frame_done,
    output logic                      sat_flag,
    input  logic                      sat_clr
);

    localparam int PW = SW + CW;
    localparam int AW = SW + CW + $clog2(V_OSC);
    localparam int MW = AW + CW;
    localparam int NCOEF = V_OSC * V_OSC;

`ifdef MODMAT_SAT_EN
    localparam logic signed [MW-1:0] LIM_HI = MW'(2 ** (OW - 1) - 1);
    localparam logic signed [MW-1:0] LIM_LO = ~LIM_HI;
`endif

    // Configuration: coef is [dst][src], depth is per destination
    logic signed [CW-1:0] coef_q  [V_OSC][V_OSC];
    logic signed [CW-1:0] coef_d  [V_OSC][V_OSC];
    logic signed [CW-1:0] depth_q [V_OSC];
    logic signed [CW-1:0] depth_d [V_OSC];

    // Stage A
    logic                 a_valid_q, a_valid_d;
    logic [V_WIDTH-1:0]   a_voice_q, a_voice_d;
    logic [O_WIDTH-1:0]   a_osc_q, a_osc_d;
    logic signed [SW-1:0] a_sample_q, a_sample_d;
    logic                 a_first_q, a_first_d;
    logic                 a_last_q, a_last_d;
    logic                 a_osc_ok;

    // Stage B
    logic                 b_valid_q, b_valid_d;
    logic [V_WIDTH-1:0]   b_voice_q, b_voice_d;
    logic                 b_first_q, b_first_d;
    logic                 b_last_q, b_last_d;
    logic signed [CW-1:0] b_sel    [V_OSC];
    logic signed [PW-1:0] b_prod_q [V_OSC];
    logic signed [PW-1:0] b_prod_d [V_OSC];

    // Stage C
    logic                 c_valid_q, c_valid_d;
    logic [V_WIDTH-1:0]   c_voice_q, c_voice_d;
    logic                 c_last_q, c_last_d;
    logic signed [AW-1:0] acc_q [V_OSC];
    logic signed [AW-1:0] acc_d [V_OSC];

    // Stage D
    logic                 d_voice_ok;
    logic                 d_commit;
    logic signed [MW-1:0] d_mul   [V_OSC];
`ifdef MODMAT_SAT_EN
    logic signed [MW-1:0] d_sh    [V_OSC];
`endif
    logic signed [OW-1:0] d_lim   [V_OSC];
    logic [V_OSC-1:0]     d_clamp;

    // Result store and outputs
    logic signed [OW-1:0] res_q [VOICES][V_OSC];
    logic signed [OW-1:0] res_d [VOICES][V_OSC];
    logic                 frame_done_q, frame_done_d;
    logic                 sat_q, sat_d;
    logic signed [OW-1:0] mod_out_q, mod_out_d;
    logic                 mod_valid_q, mod_valid_d;

    // Decode config writes; out-of-map addresses fall through untouched
    always_comb begin
        coef_d  = coef_q;
        depth_d = depth_q;
        if (cfg_we) begin
            for (int d = 0; d < V_OSC; d++) begin
                for (int s = 0; s < V_OSC; s++) begin
                    if (int'(cfg_addr) == d * V_OSC + s) begin
                        coef_d[d][s] = cfg_data;
                    end
                end
                if (int'(cfg_addr) == NCOEF + d) begin
                    depth_d[d] = cfg_data;
                end
            end
        end
    end

    // Stage A: capture the slot, flag frame start/end, drop bad osc
    always_comb begin
        a_osc_ok = 1'b0;
        for (int o = 0; o < V_OSC; o++) begin
            if (in_osc == O_WIDTH'(o)) begin
                a_osc_ok = 1'b1;
            end
        end
        a_valid_d  = in_valid && a_osc_ok;
        a_voice_d  = in_voice;
        a_osc_d    = in_osc;
        a_sample_d = in_sample;
        a_first_d  = (in_osc == '0);
        a_last_d   = (in_osc == O_WIDTH'(V_OSC - 1));
    end

    // Stage B: one product per destination using the source's column
    always_comb begin
        b_valid_d = a_valid_q;
        b_voice_d = a_voice_q;
        b_first_d = a_first_q;
        b_last_d  = a_last_q;
        for (int d = 0; d < V_OSC; d++) begin
            b_sel[d] = '0;
            for (int s = 0; s < V_OSC; s++) begin
                if (a_osc_q == O_WIDTH'(s)) begin
                    b_sel[d] = coef_q[d][s];
                end
            end
            b_prod_d[d] =
                {{CW{a_sample_q[SW-1]}}, a_sample_q} *
                {{SW{b_sel[d][CW-1]}}, b_sel[d]};
        end
    end

    // Stage C: accumulate, restarting from zero on the frame's first osc
    always_comb begin
        c_valid_d = b_valid_q;
        c_voice_d = b_voice_q;
        c_last_d  = b_last_q;
        acc_d     = acc_q;
        if (b_valid_q) begin
            for (int d = 0; d < V_OSC; d++) begin
                acc_d[d] = (b_first_q ? '0 : acc_q[d]) +
                    {{(AW - PW){b_prod_q[d][PW-1]}}, b_prod_q[d]};
            end
        end
    end

    // Stage D: depth multiply, scale and limit the finished sums
    always_comb begin
        d_voice_ok = 1'b0;
        for (int v = 0; v < VOICES; v++) begin
            if (c_voice_q == V_WIDTH'(v)) begin
                d_voice_ok = 1'b1;
            end
        end
        d_commit = c_valid_q && c_last_q && d_voice_ok;
        for (int d = 0; d < V_OSC; d++) begin
            d_mul[d] =
                {{CW{acc_q[d][AW-1]}}, acc_q[d]} *
                {{AW{depth_q[d][CW-1]}}, depth_q[d]};
            d_clamp[d] = 1'b0;
`ifdef MODMAT_SAT_EN
            d_sh[d] = d_mul[d] >>> SHIFT;
            if (d_sh[d] > LIM_HI) begin
                d_lim[d]   = OW'(LIM_HI);
                d_clamp[d] = 1'b1;
            end else if (d_sh[d] < LIM_LO) begin
                d_lim[d]   = OW'(LIM_LO);
                d_clamp[d] = 1'b1;
            end else begin
                d_lim[d] = d_sh[d][OW-1:0];
            end
`else
            d_lim[d] = OW'(d_mul[d] >>> SHIFT);
`endif
        end
    end

    // Commit a finished frame into the result store
    always_comb begin
        res_d = res_q;
        for (int v = 0; v < VOICES; v++) begin
            if (d_commit && c_voice_q == V_WIDTH'(v)) begin
                for (int d = 0; d < V_OSC; d++) begin
                    res_d[v][d] = d_lim[d];
                end
            end
        end
        frame_done_d = d_commit;
        sat_d = (sat_q && !sat_clr) || (d_commit && |d_clamp);
    end

    // Read port: registered, returns pre-commit value on a same-cycle hit
    always_comb begin
        mod_valid_d = rd_en;
        mod_out_d   = mod_out_q;
        if (rd_en) begin
            mod_out_d = '0;
            for (int v = 0; v < VOICES; v++) begin
                for (int d = 0; d < V_OSC; d++) begin
                    if (rd_voice == V_WIDTH'(v) &&
                        rd_osc == O_WIDTH'(d)) begin
                        mod_out_d = res_q[v][d];
                    end
                end
            end
        end
    end

    // All state, cleared by the asynchronous reset
    always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < V_OSC; d++) begin
                for (int s = 0; s < V_OSC; s++) begin
                    coef_q[d][s] <= '0;
                end
                depth_q[d]  <= '0;
                b_prod_q[d] <= '0;
                acc_q[d]    <= '0;
            end
            for (int v = 0; v < VOICES; v++) begin
                for (int d = 0; d < V_OSC; d++) begin
                    res_q[v][d] <= '0;
                end
            end
            a_valid_q    <= 1'b0;
            a_voice_q    <= '0;
            a_osc_q      <= '0;
            a_sample_q   <= '0;
            a_first_q    <= 1'b0;
            a_last_q     <= 1'b0;
            b_valid_q    <= 1'b0;
            b_voice_q    <= '0;
            b_first_q    <= 1'b0;
            b_last_q     <= 1'b0;
            c_valid_q    <= 1'b0;
            c_voice_q    <= '0;
            c_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            sat_q        <= 1'b0;
            mod_out_q    <= '0;
            mod_valid_q  <= 1'b0;
        end else begin
            coef_q       <= coef_d;
            depth_q      <= depth_d;
            b_prod_q     <= b_prod_d;
            acc_q        <= acc_d;
            res_q        <= res_d;
            a_valid_q    <= a_valid_d;
            a_voice_q    <= a_voice_d;
            a_osc_q      <= a_osc_d;
            a_sample_q   <= a_sample_d;
            a_first_q    <= a_first_d;
            a_last_q     <= a_last_d;
            b_valid_q    <= b_valid_d;
            b_voice_q    <= b_voice_d;
            b_first_q    <= b_first_d;
            b_last_q     <= b_last_d;
            c_valid_q    <= c_valid_d;
            c_voice_q    <= c_voice_d;
            c_last_q     <= c_last_d;
            frame_done_q <= frame_done_d;
            sat_q        <= sat_d;
            mod_out_q    <= mod_out_d;
            mod_valid_q  <= mod_valid_d;
        end
    end

    assign mod_out    = mod_out_q;
    assign mod_valid  = mod_valid_q;
    assign frame_done = frame_done_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_modulation_matrix_pipe.sv
// tb_modulation_matrix_pipe: random + directed bench with arithmetic model.
// Second instance uses SHIFT=16 so the limiter can be reached.
module tb_modulation_matrix_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              in_valid;
    logic [2:0]        in_voice;
    logic [1:0]        in_osc;
    logic signed [16:0] in_sample;
    logic              cfg_we;
    logic [4:0]        cfg_addr;
    logic signed [7:0] cfg_data;
    logic              rd_en;
    logic [2:0]        rd_voice;
    logic [1:0]        rd_osc;
    logic              sat_clr;

    logic signed [10:0] mod_out_a, mod_out_b;
    logic mod_valid_a, mod_valid_b;
    logic frame_done_a, frame_done_b;
    logic sat_a, sat_b;

    modulation_matrix_pipe dut_a (
        .sCLK_XVXENVS(clk), .reset(reset),
        .in_valid(in_valid), .in_voice(in_voice),
        .in_osc(in_osc), .in_sample(in_sample),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .rd_en(rd_en), .rd_voice(rd_voice), .rd_osc(rd_osc),
        .mod_out(mod_out_a), .mod_valid(mod_valid_a),
        .frame_done(frame_done_a), .sat_flag(sat_a),
        .sat_clr(sat_clr)
    );

    modulation_matrix_pipe #(.SHIFT(16)) dut_b (
        .sCLK_XVXENVS(clk), .reset(reset),
        .in_valid(in_valid), .in_voice(in_voice),
        .in_osc(in_osc), .in_sample(in_sample),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .rd_en(rd_en), .rd_voice(rd_voice), .rd_osc(rd_osc),
        .mod_out(mod_out_b), .mod_valid(mod_valid_b),
        .frame_done(frame_done_b), .sat_flag(sat_b),
        .sat_clr(sat_clr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int fd_count = 0;

    int     coef_m [4][4];
    int     depth_m [4];
    longint res_a [8][4];
    longint res_b [8][4];
    bit     sat_mb;

    always @(negedge clk) if (frame_done_a) fd_count++;

    task automatic check(string tag, logic signed [63:0] got,
                         logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int d = 0; d < 4; d++) begin
            depth_m[d] = 0;
            for (int s = 0; s < 4; s++) coef_m[d][s] = 0;
        end
        for (int v = 0; v < 8; v++)
            for (int d = 0; d < 4; d++) begin
                res_a[v][d] = 0;
                res_b[v][d] = 0;
            end
        sat_mb = 0;
    endtask

    function automatic longint lim_m(longint acc, int dep, int sh,
                                     output bit hit);
        longint p;
        p = (acc * dep) >>> sh;
        hit = 0;
`ifdef MODMAT_SAT_EN
        if (p > 1023) begin
            p = 1023;
            hit = 1;
        end else if (p < -1024) begin
            p = -1024;
            hit = 1;
        end
`else
        p = p & 2047;
        if (p >= 1024) p = p - 2048;
`endif
        return p;
    endfunction

    task automatic cfg_write(int addr, int val);
        cfg_we = 1;
        cfg_addr = 5'(addr);
        cfg_data = 8'(val);
        tick();
        cfg_we = 0;
        if (addr < 16) coef_m[addr / 4][addr % 4] = val;
        else if (addr < 20) depth_m[addr - 16] = val;
    endtask

    task automatic cfg_random();
        for (int a = 0; a < 20; a++)
            cfg_write(a, int'($signed(8'($urandom))));
        cfg_write(25, 85);
    endtask

    task automatic rand_samples(output int s[4]);
        for (int o = 0; o < 4; o++)
            s[o] = int'($signed(17'($urandom)));
    endtask

    task automatic send_frame(int v, int first_osc, int s[4]);
        longint acc [4];
        bit hit;
        for (int d = 0; d < 4; d++) acc[d] = 0;
        for (int o = first_osc; o < 4; o++) begin
            in_valid = 1;
            in_voice = 3'(v);
            in_osc = 2'(o);
            in_sample = 17'(s[o]);
            tick();
            for (int d = 0; d < 4; d++)
                acc[d] += longint'(coef_m[d][o]) * longint'(s[o]);
        end
        for (int d = 0; d < 4; d++) begin
            res_a[v][d] = lim_m(acc[d], depth_m[d], 24, hit);
            res_b[v][d] = lim_m(acc[d], depth_m[d], 16, hit);
            if (hit) sat_mb = 1;
        end
    endtask

    task automatic read_chk(string tag, int v, int o);
        rd_en = 1;
        rd_voice = 3'(v);
        rd_osc = 2'(o);
        tick();
        rd_en = 0;
        check({tag, "_va"}, mod_valid_a, 1);
        check({tag, "_a"}, mod_out_a, res_a[v][o]);
        check({tag, "_b"}, mod_out_b, res_b[v][o]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s [4];
        int fd0;
        longint old_a, old_b;

        reset = 1;
        in_valid = 0;
        in_voice = 0;
        in_osc = 0;
        in_sample = 0;
        cfg_we = 0;
        cfg_addr = 0;
        cfg_data = 0;
        rd_en = 0;
        rd_voice = 0;
        rd_osc = 0;
        sat_clr = 0;
        model_clear();
        repeat (3) tick();
        reset = 0;
        tick();
        check("rst_mod_valid", mod_valid_a, 0);
        check("rst_mod_out", mod_out_a, 0);
        check("rst_frame_done", frame_done_a, 0);
        check("rst_sat_a", sat_a, 0);
        check("rst_sat_b", sat_b, 0);

        rd_en = 1;
        rd_voice = 2;
        rd_osc = 1;
        tick();
        rd_en = 0;
        check("rd_rst_valid", mod_valid_a, 1);
        check("rd_rst_data", mod_out_a, 0);
        tick();
        check("rd_valid_drop", mod_valid_a, 0);

        cfg_write(4, 64);
        cfg_write(17, 64);
        s = '{65535, 0, 0, 0};
        send_frame(3, 0, s);
        in_valid = 0;
        tick();
        tick();
        check("fd_early", frame_done_a, 0);
        tick();
        check("fd_t3", frame_done_a, 1);
        rd_en = 1;
        rd_voice = 3;
        rd_osc = 1;
        tick();
        rd_en = 0;
        check("res31_15", mod_out_a, 15);
        check("res31_b", mod_out_b, res_b[3][1]);
        check("fd_pulse_end", frame_done_a, 0);
        check("sat_b_first", sat_b, sat_mb);

        sat_clr = 1;
        tick();
        sat_clr = 0;
        sat_mb = 0;
        check("sat_clr", sat_b, 0);
        cfg_write(4, 127);
        cfg_write(17, 127);
        s = '{65535, 0, 0, 0};
        send_frame(3, 0, s);
        in_valid = 0;
        repeat (4) tick();
        read_chk("sat31", 3, 1);
        check("sat_b_set", sat_b, sat_mb);
        check("sat_a_never", sat_a, 0);

        cfg_random();
        fd0 = fd_count;
        for (int v = 0; v < 8; v++) begin
            rand_samples(s);
            send_frame(v, 0, s);
        end
        in_valid = 0;
        repeat (4) tick();
        check("b2b_fd_count", fd_count - fd0, 8);
        for (int v = 0; v < 8; v++)
            for (int o = 0; o < 4; o++)
                read_chk($sformatf("b2b_v%0d_o%0d", v, o), v, o);
        check("b2b_sat_b", sat_b, sat_mb);

        old_a = res_a[7][0];
        old_b = res_b[7][0];
        rand_samples(s);
        send_frame(7, 0, s);
        in_valid = 0;
        tick();
        tick();
        rd_en = 1;
        rd_voice = 7;
        rd_osc = 0;
        tick();
        check("coll_fd", frame_done_a, 1);
        check("coll_old_a", mod_out_a, old_a);
        check("coll_old_b", mod_out_b, old_b);
        tick();
        rd_en = 0;
        check("coll_new_a", mod_out_a, res_a[7][0]);
        check("coll_new_b", mod_out_b, res_b[7][0]);

        rand_samples(s);
        for (int o = 0; o < 3; o++) begin
            in_valid = 1;
            in_voice = 5;
            in_osc = 2'(o);
            in_sample = 17'(s[o]);
            tick();
        end
        in_valid = 0;
        reset = 1;
        tick();
        reset = 0;
        model_clear();
        check("mid_rst_out", mod_out_a, 0);
        check("mid_rst_sat", sat_b, 0);
        cfg_random();
        rand_samples(s);
        send_frame(6, 1, s);
        in_valid = 0;
        repeat (4) tick();
        for (int o = 0; o < 4; o++)
            read_chk($sformatf("resume_v6_o%0d", o), 6, o);
        rand_samples(s);
        send_frame(5, 0, s);
        in_valid = 0;
        repeat (4) tick();
        for (int o = 0; o < 4; o++)
            read_chk($sformatf("post_rst_v5_o%0d", o), 5, o);
        read_chk("post_rst_v0", 0, 2);
        check("post_rst_sat_b", sat_b, sat_mb);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
